// File: rtl/axi_mem_scheduler.sv
// axi_mem_scheduler: round-robin line-transfer scheduler for write and read masters with frame bank swapping
module axi_mem_scheduler #(
  parameter logic [31:0] BASE0        = 32'h1000_0000,
  parameter logic [31:0] BASE1        = 32'h1800_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0040_0000,
  parameter logic [31:0] LINE_STRIDE  = 32'd4096,
  parameter logic [31:0] LINE_BYTES   = 32'd2048,
  parameter logic [15:0] TIMEOUT      = 16'd4095
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [1:0]  wr_req,
  input  logic [10:0] wr_line_0,
  input  logic [10:0] wr_line_1,
  output logic [1:0]  wr_ack,
  input  logic [1:0]  rd_req,
  input  logic [10:0] rd_line_0,
  input  logic [10:0] rd_line_1,
  output logic [1:0]  rd_ack,
  input  logic        wr_frame_end,
  input  logic        WR_READY,
  input  logic        WR_DONE_0,
  input  logic        WR_DONE_1,
  output logic        WR_START_0,
  output logic        WR_START_1,
  output logic [31:0] WR_ADRS_0,
  output logic [31:0] WR_ADRS_1,
  output logic [31:0] WR_LEN_0,
  output logic [31:0] WR_LEN_1,
  input  logic        RD_READY,
  input  logic        RD_DONE_0,
  input  logic        RD_DONE_1,
  output logic        RD_START_0,
  output logic        RD_START_1,
  output logic [31:0] RD_ADRS_0,
  output logic [31:0] RD_ADRS_1,
  output logic [31:0] RD_LEN_0,
  output logic [31:0] RD_LEN_1,
  output logic        wbank,
  output logic        rbank,
  output logic [1:0]  timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, ACK = 2'd3;
  logic pend, wr_defer;
  // side 0 is the write engine, side 1 the read engine; both are identical
  for (genvar s = 0; s < 2; s++) begin : side
    logic [1:0]  req, st, ack;
    logic [10:0] line0, line1;
    logic        bank, ready, done0, done1, sel, pri, nsel, dsel, tmo, start0, start1, err;
    logic [15:0] cnt;
    logic [31:0] adrs0, adrs1, nadr;
    assign req   = s == 0 ? wr_req : rd_req;
    assign line0 = s == 0 ? wr_line_0 : rd_line_0;
    assign line1 = s == 0 ? wr_line_1 : rd_line_1;
    assign bank  = s == 0 ? wbank : rbank;
    assign ready = s == 0 ? WR_READY : RD_READY;
    assign done0 = s == 0 ? WR_DONE_0 : RD_DONE_0;
    assign done1 = s == 0 ? WR_DONE_1 : RD_DONE_1;
    // channel pick (favour the one not served last), its address, and the busy-exit conditions
    always_comb begin
      nsel = req[pri] ? pri : ~pri;
      nadr = (nsel ? BASE1 : BASE0 + (bank ? FRAME_STRIDE : 32'd0)) + {21'd0, nsel ? line1 : line0} * LINE_STRIDE;
      dsel = sel ? done1 : done0;
      tmo  = st == BUSY && !dsel && cnt + 16'd1 == TIMEOUT;
    end
    // transfer FSM with registered start/ack pulses and a sticky timeout flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        st     <= IDLE;
        sel    <= 1'b0;
        pri    <= 1'b0;
        cnt    <= 16'd0;
        start0 <= 1'b0;
        start1 <= 1'b0;
        adrs0  <= 32'd0;
        adrs1  <= 32'd0;
        ack    <= 2'b00;
        err    <= 1'b0;
      end else begin
        start0 <= st == START && ready && !sel;
        start1 <= st == START && ready && sel;
        ack    <= {2{st == BUSY && dsel}} & {sel, ~sel};
        err    <= err | tmo;
        cnt    <= st == BUSY ? cnt + 16'd1 : 16'd0;
        if (st == IDLE && |req) begin
          sel <= nsel;
          pri <= ~nsel;
          if (nsel) adrs1 <= nadr;
          else adrs0 <= nadr;
        end
        st <= st == IDLE  ? (|req ? START : IDLE) :
              st == START ? (ready ? BUSY : START) :
              st == BUSY  ? (dsel ? ACK : tmo ? IDLE : BUSY) : IDLE;
      end
    end
  end
  assign WR_START_0  = side[0].start0;
  assign WR_START_1  = side[0].start1;
  assign WR_ADRS_0   = side[0].adrs0;
  assign WR_ADRS_1   = side[0].adrs1;
  assign wr_ack      = side[0].ack;
  assign RD_START_0  = side[1].start0;
  assign RD_START_1  = side[1].start1;
  assign RD_ADRS_0   = side[1].adrs0;
  assign RD_ADRS_1   = side[1].adrs1;
  assign rd_ack      = side[1].ack;
  assign timeout_err = {side[1].err, side[0].err};
  assign WR_LEN_0    = LINE_BYTES;
  assign WR_LEN_1    = LINE_BYTES;
  assign RD_LEN_0    = LINE_BYTES;
  assign RD_LEN_1    = LINE_BYTES;
  // a bank swap must not move the frame under an in-flight channel-0 write
  assign wr_defer = (side[0].st == START || side[0].st == BUSY) && !side[0].sel && !side[0].tmo;
  // bank swap with a single pending slot; extra frame_end pulses fold into it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wbank <= 1'b0;
      rbank <= 1'b1;
      pend  <= 1'b0;
    end else if ((wr_frame_end || pend) && !wr_defer) begin
      wbank <= ~wbank;
      rbank <= wbank;
      pend  <= 1'b0;
    end else if (wr_frame_end) begin
      pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_mem_scheduler.sv
// tb_axi_mem_scheduler: directed transfers checked against an address/ack scoreboard model
module tb_axi_mem_scheduler;
  localparam logic [31:0] B0 = 32'h1000_0000, B1 = 32'h1800_0000, FS = 32'h0040_0000;
  localparam logic [31:0] LS = 32'd4096, LB = 32'd2048;
  localparam int TMO = 4095;
  logic ACLK = 0, ARESETN = 0;
  logic [1:0] wr_req = 0, rd_req = 0, wr_ack, rd_ack, timeout_err;
  logic [10:0] wr_line_0 = 0, wr_line_1 = 0, rd_line_0 = 0, rd_line_1 = 0;
  logic wr_frame_end = 0, WR_READY = 0, WR_DONE_0 = 0, WR_DONE_1 = 0, RD_READY = 0, RD_DONE_0 = 0, RD_DONE_1 = 0;
  logic WR_START_0, WR_START_1, RD_START_0, RD_START_1, wbank, rbank;
  logic [31:0] WR_ADRS_0, WR_ADRS_1, WR_LEN_0, WR_LEN_1, RD_ADRS_0, RD_ADRS_1, RD_LEN_0, RD_LEN_1;
  int ntest = 0, nfail = 0;
  int outst [2] = '{0, 0};
  logic wr_rdy_q = 0, rd_rdy_q = 0;

  axi_mem_scheduler dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req(wr_req), .wr_line_0(wr_line_0), .wr_line_1(wr_line_1), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_line_0(rd_line_0), .rd_line_1(rd_line_1), .rd_ack(rd_ack),
    .wr_frame_end(wr_frame_end),
    .WR_READY(WR_READY), .WR_DONE_0(WR_DONE_0), .WR_DONE_1(WR_DONE_1),
    .WR_START_0(WR_START_0), .WR_START_1(WR_START_1), .WR_ADRS_0(WR_ADRS_0), .WR_ADRS_1(WR_ADRS_1),
    .WR_LEN_0(WR_LEN_0), .WR_LEN_1(WR_LEN_1),
    .RD_READY(RD_READY), .RD_DONE_0(RD_DONE_0), .RD_DONE_1(RD_DONE_1),
    .RD_START_0(RD_START_0), .RD_START_1(RD_START_1), .RD_ADRS_0(RD_ADRS_0), .RD_ADRS_1(RD_ADRS_1),
    .RD_LEN_0(RD_LEN_0), .RD_LEN_1(RD_LEN_1),
    .wbank(wbank), .rbank(rbank), .timeout_err(timeout_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input bit ch, input logic [10:0] ln, input bit bank);
    logic [31:0] off;
    off = 32'(ln) * LS;
    if (ch) return B1 + off;
    return B0 + (bank ? FS : 32'd0) + off;
  endfunction

  function automatic logic [1:0] starts(input int sd);
    return sd != 0 ? {RD_START_1, RD_START_0} : {WR_START_1, WR_START_0};
  endfunction

  function automatic logic [1:0] acks(input int sd);
    return sd != 0 ? rd_ack : wr_ack;
  endfunction

  function automatic logic [31:0] adrs(input int sd, input bit ch);
    if (sd != 0) return ch ? RD_ADRS_1 : RD_ADRS_0;
    return ch ? WR_ADRS_1 : WR_ADRS_0;
  endfunction

  task automatic set_done(input int sd, input bit ch, input logic v);
    if (sd == 0) begin
      if (ch) WR_DONE_1 = v; else WR_DONE_0 = v;
    end else begin
      if (ch) RD_DONE_1 = v; else RD_DONE_0 = v;
    end
  endtask

  task automatic wait_start(input int sd, input bit ch, output int cyc);
    logic [1:0] sv;
    cyc = 0;
    sv = starts(sd);
    while (sv[ch] !== 1'b1 && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      sv = starts(sd);
    end
    chk($sformatf("start side%0d ch%0d", sd, ch), 32'(sv[ch]), 32'd1);
  endtask

  task automatic pulse_done(input int sd, input bit ch);
    set_done(sd, ch, 1'b1);
    outst[sd]++;
    @(negedge ACLK);
    set_done(sd, ch, 1'b0);
  endtask

  task automatic wait_ack(input int sd, input bit ch, output int cyc);
    logic [1:0] a;
    cyc = 0;
    a = acks(sd);
    while (a == 2'b00 && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
      a = acks(sd);
    end
    chk($sformatf("ack side%0d ch%0d", sd, ch), 32'(a), ch ? 32'd2 : 32'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " starts"}, {28'd0, WR_START_1, WR_START_0, RD_START_1, RD_START_0}, 32'd0);
    chk({nm, " wr_adrs0"}, WR_ADRS_0, 32'd0);
    chk({nm, " wr_adrs1"}, WR_ADRS_1, 32'd0);
    chk({nm, " rd_adrs0"}, RD_ADRS_0, 32'd0);
    chk({nm, " rd_adrs1"}, RD_ADRS_1, 32'd0);
    chk({nm, " acks"}, {28'd0, wr_ack, rd_ack}, 32'd0);
    chk({nm, " err"}, 32'(timeout_err), 32'd0);
    chk({nm, " banks"}, {30'd0, wbank, rbank}, 32'd1);
  endtask

  always @(posedge ACLK) begin
    wr_rdy_q <= WR_READY;
    rd_rdy_q <= RD_READY;
  end

  // every-cycle scoreboard: constant LEN, legal start pulses, complementary banks, acks only for issued DONEs
  always @(negedge ACLK) begin
    if (ARESETN) begin
      ntest++;
      if ({WR_LEN_0, WR_LEN_1, RD_LEN_0, RD_LEN_1} !== {4{LB}}) begin
        nfail++;
        $display("FAIL len: got %h %h %h %h expected %h", WR_LEN_0, WR_LEN_1, RD_LEN_0, RD_LEN_1, LB);
      end
      ntest++;
      if (&starts(0) || &starts(1) || (|starts(0) && !wr_rdy_q) || (|starts(1) && !rd_rdy_q)) begin
        nfail++;
        $display("FAIL start rule: got wr=%b rd=%b ready_q=%b%b", starts(0), starts(1), wr_rdy_q, rd_rdy_q);
      end
      ntest++;
      if (wbank === rbank) begin
        nfail++;
        $display("FAIL bank complement: got wbank=%b rbank=%b", wbank, rbank);
      end
      for (int sd = 0; sd < 2; sd++) begin
        if (acks(sd) != 2'b00) begin
          ntest++;
          if (outst[sd] == 0 || acks(sd) == 2'b11) begin
            nfail++;
            $display("FAIL unexpected ack side%0d: got %b with %0d outstanding", sd, acks(sd), outst[sd]);
          end else outst[sd]--;
        end
      end
    end
  end

  initial begin
    int c, c2, n, k;
    repeat (3) @(negedge ACLK);
    ARESETN = 1;
    chk_reset_vals("reset");
    // two simultaneous write requests: ch0 first, then ch1 three cycles after ack
    WR_READY = 1;
    wr_req = 2'b11;
    wait_start(0, 0, c);
    chk("wr ch0 adrs model", WR_ADRS_0, exp_addr(0, 11'd0, 0));
    chk("wr ch0 adrs literal", WR_ADRS_0, 32'h1000_0000);
    pulse_done(0, 0);
    wait_ack(0, 0, c);
    wait_start(0, 1, c);
    chk("ack to next start", c, 3);
    chk("wr ch1 adrs literal", WR_ADRS_1, 32'h1800_0000);
    wr_req = 2'b00;
    pulse_done(0, 1);
    wait_ack(0, 1, c);
    // READY held low, then a deferred bank swap with an extra frame_end absorbed
    @(negedge ACLK);
    WR_READY = 0;
    wr_line_0 = 11'd3;
    wr_req = 2'b01;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (|starts(0)) k++;
    end
    chk("no start while not ready", k, 0);
    WR_READY = 1;
    wait_start(0, 0, c);
    chk("wr bank0 adrs literal", WR_ADRS_0, 32'h1000_3000);
    wr_req = 2'b00;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      if (|starts(0)) k++;
      wr_frame_end = (i == 1 || i == 3);
    end
    chk("single start pulse", k, 0);
    chk("banks held during busy", {30'd0, wbank, rbank}, 32'd1);
    pulse_done(0, 0);
    wait_ack(0, 0, c);
    chk("banks in ack cycle", {30'd0, wbank, rbank}, 32'd1);
    @(negedge ACLK);
    chk("banks after ack", {30'd0, wbank, rbank}, 32'd2);
    repeat (3) @(negedge ACLK);
    chk("pending swap absorbed", {30'd0, wbank, rbank}, 32'd2);
    wr_req = 2'b01;
    wait_start(0, 0, c);
    chk("wr bank1 adrs model", WR_ADRS_0, exp_addr(0, 11'd3, 1));
    chk("wr bank1 adrs literal", WR_ADRS_0, 32'h1040_3000);
    chk("wr len0", WR_LEN_0, 32'd2048);
    wr_req = 2'b00;
    pulse_done(0, 0);
    wait_ack(0, 0, c);
    // reads: latched ch0 address survives a swap, other-channel DONE ignored
    RD_READY = 1;
    rd_line_0 = 11'd2;
    rd_req = 2'b01;
    wait_start(1, 0, c);
    chk("rd ch0 adrs literal", RD_ADRS_0, 32'h1000_2000);
    rd_req = 2'b00;
    wr_frame_end = 1;
    @(negedge ACLK);
    wr_frame_end = 0;
    @(negedge ACLK);
    chk("idle swap immediate", {30'd0, wbank, rbank}, 32'd1);
    chk("rd latched adrs kept", RD_ADRS_0, exp_addr(0, 11'd2, 0));
    pulse_done(1, 0);
    wait_ack(1, 0, c);
    rd_line_1 = 11'd5;
    rd_req = 2'b10;
    wait_start(1, 1, c);
    chk("rd ch1 adrs model", RD_ADRS_1, exp_addr(1, 11'd5, 0));
    chk("rd ch1 adrs literal", RD_ADRS_1, 32'h1800_5000);
    rd_req = 2'b00;
    RD_DONE_0 = 1;
    @(negedge ACLK);
    RD_DONE_0 = 0;
    @(negedge ACLK);
    chk("other done ignored", 32'(rd_ack), 32'd0);
    pulse_done(1, 1);
    wait_ack(1, 1, c);
    // read timeout while a write completes normally
    rd_line_1 = 11'd1;
    rd_req = 2'b10;
    wait_start(1, 1, c);
    rd_req = 2'b00;
    n = 0;
    fork
      begin
        while (timeout_err[1] !== 1'b1 && n < 6000) begin
          @(negedge ACLK);
          n++;
        end
      end
      begin
        wr_line_1 = 11'd7;
        wr_req = 2'b10;
        wait_start(0, 1, c2);
        chk("wr during rd busy adrs", WR_ADRS_1, 32'h1800_7000);
        wr_req = 2'b00;
        pulse_done(0, 1);
        wait_ack(0, 1, c2);
      end
    join
    chk("timeout cycles", n, TMO);
    chk("timeout_err read only", 32'(timeout_err), 32'd2);
    @(negedge ACLK);
    rd_line_0 = 11'd0;
    rd_req = 2'b01;
    wait_start(1, 0, c);
    chk("rd idle after timeout", c, 2);
    chk("rd rbank1 adrs", RD_ADRS_0, 32'h1040_0000);
    chk("timeout_err sticky", 32'(timeout_err), 32'd2);
    // asynchronous reset in the middle of a read BUSY
    rd_req = 2'b00;
    repeat (3) @(negedge ACLK);
    ARESETN = 0;
    #1;
    chk_reset_vals("mid reset");
    @(negedge ACLK);
    ARESETN = 1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (rd_ack != 2'b00 || |starts(1)) k++;
    end
    chk("no rd activity after reset", k, 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
